// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, runs a req/ack fetch handshake with a one-entry skid for
// words returning under stall, and handles jr/jump/branch redirects with
// squashing of a fetch that is still in flight.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_plus4_o,
  output logic [5:0]  opcode_o,
  output logic [5:0]  funct_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [15:0] imm_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SKID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] skid_q, skid_d;
  logic        squash_q, squash_d;

  logic        redirect_s;
  logic [31:0] target_raw_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  assign redirect_s = jr_i | jump_i | branch_taken_i;
  assign pc_plus4_s = pc_q + 32'd4;  // wraps modulo 2^32

  // Select the redirect target by priority jr > jump > branch and word-align it.
  always_comb begin
    target_raw_s = branch_target_i;
    if (jr_i) begin
      target_raw_s = jr_target_i;
    end else if (jump_i) begin
      target_raw_s = {id_pc4_q[31:28], jump_index_i, 2'b00};
    end else begin
      target_raw_s = branch_target_i;
    end
    target_s = {target_raw_s[31:2], 2'b00};
  end

  // Next-state logic for the fetch FSM, PC, request outputs, skid and IF/ID.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    skid_d   = skid_q;
    squash_d = squash_q;
    id_pc4_d = id_pc4_q;
    // Under stall IF/ID holds; otherwise it drains to a bubble unless refilled.
    if (stall_i) begin
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
    end else begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end

    if (redirect_s) begin
      // Redirect wins over stall: flush IF/ID, drop the skid, retarget the PC.
      pc_d       = target_s;
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      skid_d     = NOP_INSTR;
      if ((state_q == ST_WAIT) && !imem_ack_i) begin
        // Request still in flight: address must stay put, discard its ack later.
        squash_d = 1'b1;
        state_d  = ST_WAIT;
      end else if (!stall_i) begin
        squash_d = 1'b0;
        req_d    = 1'b1;
        addr_d   = target_s;
        state_d  = ST_WAIT;
      end else begin
        squash_d = 1'b0;
        req_d    = 1'b0;
        state_d  = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stall_i) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = ST_WAIT;
          end else begin
            req_d   = 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_ack_i) begin
            if (squash_q) begin
              // Stale word from before a redirect: drop it and fetch the target.
              squash_d = 1'b0;
              if (!stall_i) begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                state_d = ST_WAIT;
              end else begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
              end
            end else if (!stall_i) begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rdata_i;
              id_pc4_d   = pc_plus4_s;
              pc_d       = pc_plus4_s;
              req_d      = 1'b1;
              addr_d     = pc_plus4_s;
              state_d    = ST_WAIT;
            end else begin
              skid_d  = imem_rdata_i;
              pc_d    = pc_plus4_s;
              req_d   = 1'b0;
              state_d = ST_SKID;
            end
          end else begin
            req_d   = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_SKID: begin
          req_d = 1'b0;
          if (!stall_i) begin
            // pc already points past the skidded word, so it is the link value.
            id_valid_d = 1'b1;
            id_instr_d = skid_q;
            id_pc4_d   = pc_q;
            skid_d     = NOP_INSTR;
            state_d    = ST_IDLE;
          end else begin
            state_d    = ST_SKID;
          end
        end
        default: begin
          req_d    = 1'b0;
          squash_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc4_q   <= 32'h0000_0000;
      skid_q     <= NOP_INSTR;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      skid_q     <= skid_d;
      squash_q   <= squash_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign id_valid_o    = id_valid_q;
  assign id_instr_o    = id_instr_q;
  assign id_pc_plus4_o = id_pc4_q;
  assign opcode_o      = id_instr_q[31:26];
  assign rs_o          = id_instr_q[25:21];
  assign rt_o          = id_instr_q[20:16];
  assign rd_o          = id_instr_q[15:11];
  assign shamt_o       = id_instr_q[10:6];
  assign funct_o       = id_instr_q[5:0];
  assign imm_o         = id_instr_q[15:0];

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the control unit.
- Holds the PC and issues word fetches over a req/ack instruction-memory handshake.
- Captures the returned instruction and splits it into opcode/funct/rs/rt/rd/shamt/imm fields. opcode and funct drive the control unit; the rest feed the register file and sign-extender.
- Accepts stall from hazard logic and redirects (branch, j/jal, jr) from downstream stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction presented on IF/ID when invalid or flushed (sll $0,$0,0).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold IF/ID contents; no new fetch issued
- branch_taken  in  1  taken conditional branch, resolved downstream
- branch_target  in  32  absolute branch target
- jump  in  1  j/jal in ID; target computed here
- jump_index  in  26  instr[25:0] of the jump
- jr  in  1  jr resolved; highest redirect priority
- jr_target  in  32  register value for jr
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  word-aligned fetch address, registered
- imem_ack  in  1  fetch completes this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  32  IF/ID instruction
- id_pc_plus4  out  32  PC+4 of id_instr (jal link value)
- opcode  out  6  id_instr[31:26]
- funct  out  6  id_instr[5:0]
- rs, rt, rd  out  5 each  id_instr[25:21], [20:16], [15:11]
- shamt  out  5  id_instr[10:6]
- imm  out  16  id_instr[15:0]

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_instr=NOP_INSTR, id_pc_plus4=0.
  - Skid empty, squash flag clear, state IDLE.
  - Reset mid-request drops the request with no wait for ack; an ack in the cycle after reset is ignored.
- Field outputs are pure slices of the id_instr register, so they are NOP fields whenever id_valid=0.
- States:
  - IDLE: no request outstanding. Next cycle asserts imem_req with imem_addr=pc unless stall=1 → WAIT.
  - WAIT: imem_req=1 and imem_addr held stable until imem_ack.
    - On ack with stall=0: load IF/ID, pc+=4, id_valid=1.
    - Back-to-back: imem_req stays 1 and imem_addr=new pc next cycle. Zero-wait memory (ack same cycle as req) sustains 1 instr/cycle.
    - On ack with stall=1: word goes to the one-entry skid, pc+=4 → SKID.
  - SKID: imem_req=0; IF/ID held. When stall drops, skid moves to IF/ID with id_valid=1 → IDLE, which issues the next fetch the following cycle.
- Stall with no outstanding request: remain IDLE, imem_req=0, IF/ID held.
- Redirect priority: jr > jump > branch_taken. Target:
  - jr: jr_target.
  - jump: {id_pc_plus4[31:28], jump_index, 2'b00}.
  - branch: branch_target.
- Redirect effect (overrides stall in the same cycle):
  - pc=target; IF/ID flushed (id_valid=0, id_instr=NOP_INSTR); skid cleared.
  - If a request is outstanding and not acked this cycle, set squash; its later ack is discarded, then the fetch of target issues next cycle.
  - If acked this cycle, the data is discarded.
  - Otherwise the next request uses target the following cycle.
- Redirect arriving during squash: latest target wins; still only one discarded ack.
- Address width: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). Targets with addr[1:0]≠0 are forced to 00.
- imem_addr never changes while imem_req=1 and ack not received.

Test Plan:
- Reset then zero-wait memory returning 0x20080005 (addi $8,$0,5) at 0x0: imem_addr 0,4,8 on consecutive cycles; cycle 2 id_valid=1, opcode=001000, rt=8, imm=5, id_pc_plus4=4.
- Memory acking after 3 cycles: imem_addr=0 held 3 cycles with req=1; id_valid rises the cycle after ack; no second fetch overlaps.
- stall=1 for 4 cycles while a fetch of 0x8C090000 (lw) is outstanding: word held in skid, IF/ID unchanged, imem_req=0. After release the lw appears in IF/ID next cycle; fetch of pc+4 issues one cycle later.
- jump=1, jump_index=26'h0000040, id_pc_plus4=0x0040_0010: IF/ID flushed next cycle, next imem_addr=0x0000_0100. Same-cycle jr=1, jr_target=0x500: imem_addr=0x500.
- branch_taken with 2-cycle-latency memory mid-request: the in-flight ack is discarded (id_valid stays 0); the next request is to branch_target.
- rst asserted during WAIT, ack one cycle later: ack ignored; outputs at reset values; first fetch at RESET_PC.
